// File: rtl/skip_count_checker.sv
// skip_count_checker: locks onto a skip up/down counter stream and counts prediction mismatches.
// Optional first-mismatch snapshot ports are enabled by defining SKIPCHK_SNAPSHOT_EN.
module skip_count_checker #(
    parameter int W           = 4,
    parameter int TOP         = 14,
    parameter int BOTTOM      = 1,
    parameter int UP_SKIP     = 3,
    parameter int DOWN_SKIP   = 5,
    parameter int LOSS_THRESH = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         locked,
    output logic         dir_down,
    output logic [W-1:0] expected,
    output logic         err_pulse,
    output logic [15:0]  err_count
`ifdef SKIPCHK_SNAPSHOT_EN
    ,
    output logic         snap_valid,
    output logic [W-1:0] snap_rx,
    output logic [W-1:0] snap_exp
`endif
);
    localparam logic [W-1:0] TOP_V = W'(TOP);
    localparam logic [W-1:0] BOT_V = W'(BOTTOM);
    localparam logic [W-1:0] UP_V  = W'(UP_SKIP);
    localparam logic [W-1:0] DN_V  = W'(DOWN_SKIP);
    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [3:0]   LAST_MISS = 4'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    // Returns {new_dir, next_value}; the turnaround picks the direction first, then steps in it.
    function automatic logic [W:0] succ(input logic [W-1:0] v, input logic d);
        logic         nd;
        logic [W-1:0] n;
        nd = d ? (v > BOT_V) : (v >= TOP_V);
        n  = nd ? v - ONE : v + ONE;
        n  = nd ? ((n == DN_V) ? n - ONE : n) : ((n == UP_V) ? n + ONE : n);
        return {nd, n};
    endfunction

    state_t       state_q;
    logic [W-1:0] prev_q, exp_q;
    logic         dir_q, locked_q, err_q;
    logic [15:0]  cnt_q;
    logic [3:0]   miss_q;
    logic [W:0]   up_c, dn_c, lk_c, nx_c;
    logic         mis;

    always_comb begin
        up_c = succ(prev_q, 1'b0);
        dn_c = succ(prev_q, 1'b1);
        lk_c = succ(exp_q, dir_q);
        nx_c = succ(in_data, (in_data == up_c[W-1:0]) ? up_c[W] : dn_c[W]);
        mis  = in_data != exp_q;
    end

`ifdef SKIPCHK_SNAPSHOT_EN
    logic         snap_valid_q;
    logic [W-1:0] snap_rx_q, snap_exp_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_valid_q <= 1'b0;
            snap_rx_q    <= '0;
            snap_exp_q   <= '0;
        end else if (in_valid && state_q == LOCKED && mis && !snap_valid_q) begin
            snap_valid_q <= 1'b1;
            snap_rx_q    <= in_data;
            snap_exp_q   <= exp_q;
        end
    end
    assign snap_valid = snap_valid_q;
    assign snap_rx    = snap_rx_q;
    assign snap_exp   = snap_exp_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            prev_q   <= '0;
            exp_q    <= '0;
            dir_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            miss_q   <= '0;
        end else begin
            err_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    HUNT: begin
                        prev_q  <= in_data;
                        state_q <= CONFIRM;
                    end
                    CONFIRM: begin
                        if (in_data == up_c[W-1:0] || in_data == dn_c[W-1:0]) begin
                            state_q        <= LOCKED;
                            locked_q       <= 1'b1;
                            {dir_q, exp_q} <= nx_c;
                        end else begin
                            prev_q <= in_data;
                        end
                    end
                    default: begin
                        // Flywheel: the prediction advances from itself, never from the sample.
                        {dir_q, exp_q} <= lk_c;
                        err_q          <= mis;
                        if (mis) begin
                            cnt_q <= cnt_q + 16'(cnt_q != 16'hFFFF);
                            if (miss_q == LAST_MISS) begin
                                state_q  <= HUNT;
                                locked_q <= 1'b0;
                                miss_q   <= '0;
                            end else begin
                                miss_q <= miss_q + 4'd1;
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign locked    = locked_q;
    assign dir_down  = dir_q;
    assign expected  = exp_q;
    assign err_pulse = err_q;
    assign err_count = cnt_q;
endmodule

// File: doc/skip_count_checker.md
Name: skip_count_checker

Overview:
- Receive-side monitor for the skip up/down counter stream.
- Observes a sampled counter value, acquires lock on the sequence, then predicts every next value and flags deviations.
- Up phase skips UP_SKIP; down phase skips DOWN_SKIP; direction reverses at TOP and BOTTOM.
- Sits next to the counter, or after a link carrying its value, as a self-check and error-statistics block.

Parameters:
- W, 4, data width.
- TOP, 14, value at which the up phase turns to down.
- BOTTOM, 1, value at which the down phase turns to up.
- UP_SKIP, 3, value never produced while counting up.
- DOWN_SKIP, 5, value never produced while counting down.
- LOSS_THRESH, 3, consecutive mismatches in LOCKED that drop lock (range 1..15).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous reset, active-high.
- in_valid, input, 1, in_data holds a sample this cycle.
- in_data, input, W, observed counter value.
- locked, output, 1, sequence tracked.
- dir_down, output, 1, current predicted direction (1 = counting down).
- expected, output, W, value predicted for the next valid sample.
- err_pulse, output, 1, one-cycle strobe on mismatch in LOCKED.
- err_count, output, 16, total mismatches; saturates at 16'hFFFF.

Behaviour:
- Reset: state=HUNT; locked=0, dir_down=0, expected=0, err_pulse=0, err_count=0, miss counter=0. Reset mid-operation aborts lock immediately.
- Successor function succ(v, d), combinational:
  - d=up, v>=TOP: direction becomes down; n=v-1, or v-2 if v-1==DOWN_SKIP.
  - d=up otherwise: n=v+1, or v+2 if v+1==UP_SKIP.
  - d=down, v<=BOTTOM: direction becomes up; n=v+1, or v+2 if v+1==UP_SKIP.
  - d=down otherwise: n=v-1, or v-2 if v-1==DOWN_SKIP.
  - Arithmetic is modulo 2^W. Returns the new value and the new direction.
- Cycles with in_valid=0 change nothing except err_pulse, which is deasserted.
- HUNT: on a valid sample, store prev=in_data and go to CONFIRM.
- CONFIRM, on a valid sample s:
  - s==succ(prev,up): go LOCKED with direction from succ(prev,up).
  - else s==succ(prev,down): go LOCKED with direction from succ(prev,down).
  - else: prev=s and stay in CONFIRM.
  - The up candidate wins if both match.
  - On entering LOCKED: expected=succ(s,dir), locked=1 on the following cycle.
- LOCKED, on a valid sample s:
  - Both cases: expected<=succ(expected,dir) and dir updates (flywheel; prediction never resyncs to s).
  - s==expected: miss counter=0.
  - s!=expected: err_pulse=1 next cycle, err_count+1 (saturating), miss counter+1.
  - When miss counter reaches LOSS_THRESH: go HUNT next cycle, locked=0, miss counter=0. err_count is retained.
- Latency: locked, err_pulse and expected update one cycle after the qualifying valid sample.
- err_count is cleared only by rst.

Optional Feature:
- Macro SKIPCHK_SNAPSHOT_EN.
- When defined, adds outputs snap_valid (1), snap_rx (W) and snap_exp (W).
  - On the first mismatch after reset, captures the received and expected values and sets snap_valid.
  - Later mismatches do not overwrite the capture.
  - rst clears all three outputs.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then clean stream 0,1,2,4,5 -> locked=1 after sample 1; expected=6 after sample 5; err_count=0.
- Locked clean stream across top turnaround 12,13,14,13,12 and bottom sequence 7,6,4,3,2,1,2,4 -> no err_pulse; dir_down goes 1 after 14 and 0 after 1.
- Locked, expected=8, inject 9 then 9,10 correct -> one err_pulse; err_count=1; locked stays 1; miss counter cleared.
- Locked, three consecutive wrong samples (15,15,15) -> err_count=3; locked=0 one cycle after the third; a following clean pair re-acquires.
- HUNT with samples 7,3,6,4 -> CONFIRM retries at 7→3; locks down on 6→4; dir_down=1; expected=3. Then assert rst mid-stream -> all outputs return to reset values next cycle.
- With SKIPCHK_SNAPSHOT_EN: mismatch 9 vs expected 8, then mismatch 0 vs expected 11 -> snap_rx=9, snap_exp=8, snap_valid=1, unchanged by the second mismatch.
